// File: rtl/dram_pkg.sv
// dram_pkg: shared state encoding and bus widths for the DRAM controller
package dram_pkg;
  localparam int ROW_W  = 10;
  localparam int COL_W  = 8;
  localparam int ADDR_W = 18;
  localparam int DQ_W   = 16;
  typedef enum logic [3:0] {
    IDLE, ROW_SETUP, RAS_ACT, COL_SETUP, CAS_ACT, PRECHARGE, REF_CAS, REF_RAS, REF_PRE
  } state_e;
endpackage

// File: rtl/dram_ref_timer.sv
// dram_ref_timer: free-running interval counter that raises a single pending refresh flag
module dram_ref_timer #(
  parameter int REF_INTERVAL = 780
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ref_clear,
  output logic ref_pending
);
  localparam int CW = $clog2(REF_INTERVAL);
  logic [CW-1:0] cnt_q;
  logic pend_q;
  logic wrap;
  assign wrap = cnt_q == CW'(REF_INTERVAL - 1);
  assign ref_pending = pend_q;
  // wrap sets the flag (a second wrap is absorbed); entering refresh clears it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + CW'(1);
      pend_q <= wrap ? 1'b1 : (ref_clear ? 1'b0 : pend_q);
    end
  end
endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: sequences RAS/CAS reads, byte-masked early writes and CBR refresh for a 256Kx16 DRAM
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2,
  parameter int T_RAS        = 3,
  parameter int REF_INTERVAL = 780
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              WR,
  input  logic [1:0]        BE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DQ_W-1:0]   WDATA,
  output logic              ACK,
  output logic [DQ_W-1:0]   RDATA,
  output logic              BUSY,
  output logic [ROW_W-1:0]  MA,
  output logic              RAS_N,
  output logic              CAS_N,
  output logic              LWE_N,
  output logic              UWE_N,
  output logic              OE_N,
  output logic [DQ_W-1:0]   DQ_OUT,
  output logic              DQ_OE,
  input  logic [DQ_W-1:0]   DQ_IN
);
  state_e state_q;
  logic [7:0] cnt_q, lim;
  logic last, ref_pending, ref_clear;
  logic wr_q, ack_q, busy_q, dq_oe_q;
  logic ras_n_q, cas_n_q, lwe_n_q, uwe_n_q, oe_n_q;
  logic [1:0] be_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] ma_q;
  logic [DQ_W-1:0] wdata_q, rdata_q, dq_out_q;

  dram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref (
    .CLK(CLK), .RESET(RESET), .ref_clear(ref_clear), .ref_pending(ref_pending)
  );

  // dwell length of the current timed state; last marks its final cycle
  always_comb begin
    lim  = state_q == RAS_ACT ? 8'(T_RCD) :
           state_q == CAS_ACT ? 8'(T_CAS) :
           state_q == REF_RAS ? 8'(T_RAS) : 8'(T_RP);
    last = cnt_q == lim - 8'd1;
  end

  assign ref_clear = state_q == IDLE && ref_pending;

  // FSM with every pin output registered on the edge that enters its state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ma_q     <= '0;
      ras_n_q  <= 1'b1;
      cas_n_q  <= 1'b1;
      lwe_n_q  <= 1'b1;
      uwe_n_q  <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      col_q    <= '0;
      wdata_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      cnt_q <= cnt_q + 8'd1;
      case (state_q)
        IDLE:
          if (ref_pending) begin
            state_q <= REF_CAS;
            cas_n_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (REQ) begin
            state_q <= ROW_SETUP;
            busy_q  <= 1'b1;
            wr_q    <= WR;
            be_q    <= BE;
            col_q   <= ADDR[COL_W-1:0];
            wdata_q <= WDATA;
            ma_q    <= ADDR[ADDR_W-1:COL_W];
          end
        ROW_SETUP: begin
          state_q <= RAS_ACT;
          ras_n_q <= 1'b0;
          cnt_q   <= '0;
        end
        RAS_ACT:
          if (last) begin
            state_q <= COL_SETUP;
            ma_q    <= {2'b00, col_q};
            if (wr_q) begin
              lwe_n_q  <= ~be_q[0];
              uwe_n_q  <= ~be_q[1];
              dq_out_q <= wdata_q;
              dq_oe_q  <= |be_q;
            end
          end
        COL_SETUP: begin
          state_q <= CAS_ACT;
          cas_n_q <= 1'b0;
          oe_n_q  <= wr_q;
          cnt_q   <= '0;
        end
        CAS_ACT:
          if (last) begin
            state_q <= PRECHARGE;
            ack_q   <= 1'b1;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            lwe_n_q <= 1'b1;
            uwe_n_q <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            cnt_q   <= '0;
            if (!wr_q) rdata_q <= DQ_IN;
          end
        PRECHARGE, REF_PRE:
          if (last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        REF_CAS: begin
          state_q <= REF_RAS;
          ras_n_q <= 1'b0;
          cnt_q   <= '0;
        end
        REF_RAS:
          if (last) begin
            state_q <= REF_PRE;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            cnt_q   <= '0;
          end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ACK    = ack_q;
  assign RDATA  = rdata_q;
  assign BUSY   = busy_q;
  assign MA     = ma_q;
  assign RAS_N  = ras_n_q;
  assign CAS_N  = cas_n_q;
  assign LWE_N  = lwe_n_q;
  assign UWE_N  = uwe_n_q;
  assign OE_N   = oe_n_q;
  assign DQ_OUT = dq_out_q;
  assign DQ_OE  = dq_oe_q;
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed bench with a behavioural DRAM model driven by the controller pins
module tb_dram_ctrl;
  logic CLK, RESET, REQ, WR, ACK, BUSY, RAS_N, CAS_N, LWE_N, UWE_N, OE_N, DQ_OE;
  logic [1:0] BE;
  logic [17:0] ADDR;
  logic [15:0] WDATA, RDATA, DQ_OUT, DQ_IN;
  logic [9:0] MA;

  dram_ctrl dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WR(WR), .BE(BE), .ADDR(ADDR), .WDATA(WDATA),
    .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY), .MA(MA), .RAS_N(RAS_N), .CAS_N(CAS_N),
    .LWE_N(LWE_N), .UWE_N(UWE_N), .OE_N(OE_N), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .DQ_IN(DQ_IN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] mem [0:262143];
  logic [9:0] row, ras_ma, cas_ma;
  logic [7:0] col;
  int ref_cnt = 0, ack_cnt = 0, we_lo = 0, cyc = 0, last_ack = 0;
  int b9 = 0, b16 = 0, bo = 0;
  bit have_prev = 0, gap_en = 0;
  int n_chk = 0, n_fail = 0;

  // DRAM: row latched on RAS fall, column and early write on CAS fall; CAS-before-RAS is a refresh
  always @(negedge RAS_N) begin
    row = MA;
    ras_ma = MA;
  end
  always @(negedge CAS_N) begin
    cas_ma = MA;
    if (RAS_N) ref_cnt++;
    else begin
      col = MA[7:0];
      if (!LWE_N) mem[{row, col}][7:0] = DQ_OUT[7:0];
      if (!UWE_N) mem[{row, col}][15:8] = DQ_OUT[15:8];
    end
  end
  assign DQ_IN = (!RAS_N && !CAS_N && !OE_N) ? mem[{row, col}] : 16'hDEAD;

  always @(negedge CLK) begin
    cyc++;
    if (!LWE_N || !UWE_N || !OE_N) we_lo++;
    if (ACK) begin
      ack_cnt++;
      if (gap_en && have_prev) begin
        if (cyc - last_ack == 9) b9++;
        else if (cyc - last_ack == 16) b16++;
        else bo++;
      end
      last_ack = cyc;
      have_prev = gap_en;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [1:0] be, input logic [17:0] a,
                        input logic [15:0] wd, input string tag);
    int t, st;
    t = 0;
    st = -1;
    REQ = 1'b1; WR = wr; BE = be; ADDR = a; WDATA = wd;
    while (!ACK && t < 40) begin
      tick();
      t++;
      if (BUSY && st < 0) st = t;
      if (st > 0) begin WR = ~wr; BE = ~be; ADDR = ~a; WDATA = ~wd; end
    end
    REQ = 1'b0;
    chk({tag, "_ack_latency"}, 32'(t - st), 32'd6);
    tick();
    tick();
  endtask

  int t, a0, r0, w0;
  initial begin
    RESET = 1'b1; REQ = 1'b0; WR = 1'b0; BE = 2'b00; ADDR = '0; WDATA = '0;
    repeat (3) tick();
    RESET = 1'b0;
    chk("rst_strobes", {RAS_N, CAS_N, LWE_N, UWE_N, OE_N}, 5'b11111);
    chk("rst_ma", MA, 0);
    chk("rst_dq", {DQ_OE, DQ_OUT}, 0);
    chk("rst_ack_busy", {ACK, BUSY}, 0);
    chk("rst_rdata", RDATA, 0);

    access(1'b1, 2'b11, 18'h2A5C3, 16'hBEEF, "wr_beef");
    chk("wr_ras_ma", ras_ma, 10'h2A5);
    chk("wr_cas_ma", cas_ma, 10'h0C3);
    access(1'b0, 2'b00, 18'h2A5C3, 16'h0000, "rd_beef");
    chk("rd_ras_ma", ras_ma, 10'h2A5);
    chk("rd_cas_ma", cas_ma, 10'h0C3);
    chk("rd_beef_data", RDATA, 16'hBEEF);

    access(1'b1, 2'b11, 18'h0, 16'h1234, "wr_1234");
    access(1'b1, 2'b01, 18'h0, 16'hFF56, "wr_lo56");
    access(1'b0, 2'b00, 18'h0, 16'h0000, "rd_1256");
    chk("rd_1256_data", RDATA, 16'h1256);
    access(1'b1, 2'b10, 18'h0, 16'hAB00, "wr_hiab");
    access(1'b0, 2'b00, 18'h0, 16'h0000, "rd_ab56");
    chk("rd_ab56_data", RDATA, 16'hAB56);

    w0 = we_lo;
    access(1'b1, 2'b00, 18'h0, 16'h9999, "wr_be00");
    chk("be00_no_strobes", 32'(we_lo - w0), 0);
    chk("be00_rdata_kept", RDATA, 16'hAB56);
    access(1'b0, 2'b00, 18'h0, 16'h0000, "rd_be00");
    chk("be00_mem_kept", RDATA, 16'hAB56);

    REQ = 1'b1; WR = 1'b1; BE = 2'b11; ADDR = 18'h00100; WDATA = 16'h5555;
    t = 0;
    while (CAS_N && t < 20) begin tick(); t++; end
    chk("abort_reached_cas", CAS_N, 1'b0);
    a0 = ack_cnt;
    r0 = ref_cnt;
    RESET = 1'b1; REQ = 1'b0;
    tick();
    RESET = 1'b0;
    chk("abort_strobes", {RAS_N, CAS_N, LWE_N, UWE_N, OE_N}, 5'b11111);
    chk("abort_dq_oe", DQ_OE, 1'b0);
    chk("abort_ack_busy", {ACK, BUSY}, 0);
    repeat (780) tick();
    chk("abort_no_ack", 32'(ack_cnt - a0), 0);
    chk("ref_not_early", {CAS_N, BUSY}, 2'b10);

    REQ = 1'b1; WR = 1'b0; ADDR = 18'h0;
    tick();
    chk("coll_ref_cas", {CAS_N, RAS_N, BUSY}, 3'b011);
    t = 1;
    while (!ACK && t < 40) begin tick(); t++; end
    REQ = 1'b0;
    chk("coll_ack_latency", 32'(t), 32'd14);
    chk("coll_rdata", RDATA, 16'hAB56);
    repeat (3) tick();
    chk("coll_single_ack", 32'(ack_cnt - a0), 1);
    chk("coll_single_ref", 32'(ref_cnt - r0), 1);

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    r0 = ref_cnt;
    gap_en = 1'b1;
    REQ = 1'b1; WR = 1'b0; ADDR = 18'h2A5C3;
    repeat (7850) tick();
    t = 0;
    while (!ACK && t < 40) begin tick(); t++; end
    REQ = 1'b0;
    gap_en = 1'b0;
    chk("stream_final_ack", ACK, 1'b1);
    chk("stream_rdata", RDATA, 16'hBEEF);
    repeat (3) tick();
    chk("stream_ref_count", 32'(ref_cnt - r0), 10);
    chk("stream_ref_gaps", 32'(b16), 10);
    chk("stream_bad_gaps", 32'(bo), 0);
    chk("stream_has_9_gaps", 32'(b9 > 800), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
